// File: rtl/pb_port_master_if.sv
`default_nettype none
// ============================================================================
// Module   : pb_port_master_if
// Brief    : Command, read-response and port-bus signal bundle for pb_port_master.
// Revision : 1.0 - initial release
// ============================================================================
interface pb_port_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] rsp_addr;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, in_port,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr,
        output port_id, out_port, write_strobe, read_strobe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, in_port,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr,
        input  port_id, out_port, write_strobe, read_strobe
    );
endinterface
`default_nettype wire

// File: rtl/pb_port_master.sv
`default_nettype none
// ============================================================================
// Module   : pb_port_master
// Brief    : Turns single read/write commands into port-bus cycles; optional
//            interrupt capture enabled by macro PB_PORT_MASTER_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pb_port_master #(
    parameter logic [7:0] IDLE_PORT_ID = 8'hFF
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pb_port_master_if.master   bus,
    input  wire logic          interrupt,
    input  wire logic          irq_clear,
    output logic               irq_pending,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_accept;

    logic [7:0] r_addr;
    logic       r_write;

    logic       r_cmd_ready,    w_cmd_ready_d;
    logic       r_busy,         w_busy_d;
    logic [7:0] r_port_id,      w_port_id_d;
    logic [7:0] r_out_port,     w_out_port_d;
    logic       r_write_strobe, w_write_strobe_d;
    logic       r_read_strobe,  w_read_strobe_d;
    logic       r_rsp_valid,    w_rsp_valid_d;
    logic [7:0] r_rsp_data,     w_rsp_data_d;
    logic [7:0] r_rsp_addr,     w_rsp_addr_d;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid && r_cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_STROBE;
            S_STROBE: w_next_state = r_write ? S_IDLE : S_RESP;
            S_RESP:   if (bus.rsp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one comes straight off a flop.
    always_comb begin
        w_cmd_ready_d    = (w_next_state == S_IDLE);
        w_busy_d         = (w_next_state != S_IDLE);
        w_write_strobe_d = (w_next_state == S_STROBE) &&  r_write;
        w_read_strobe_d  = (w_next_state == S_STROBE) && !r_write;
        w_rsp_valid_d    = (w_next_state == S_RESP);
        w_port_id_d      = IDLE_PORT_ID;
        w_out_port_d     = r_out_port;
        w_rsp_data_d     = r_rsp_data;
        w_rsp_addr_d     = r_rsp_addr;
        if (w_accept) begin
            w_port_id_d = bus.cmd_addr;
            if (bus.cmd_write) begin
                w_out_port_d = bus.cmd_wdata;
            end
        end else if (w_next_state == S_STROBE) begin
            w_port_id_d = r_port_id;
        end
        if ((r_state == S_STROBE) && !r_write) begin
            w_rsp_data_d = bus.in_port;
            w_rsp_addr_d = r_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr         <= 8'h00;
            r_write        <= 1'b0;
            r_cmd_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_port_id      <= IDLE_PORT_ID;
            r_out_port     <= 8'h00;
            r_write_strobe <= 1'b0;
            r_read_strobe  <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= 8'h00;
            r_rsp_addr     <= 8'h00;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.cmd_addr;
                r_write <= bus.cmd_write;
            end
            r_cmd_ready    <= w_cmd_ready_d;
            r_busy         <= w_busy_d;
            r_port_id      <= w_port_id_d;
            r_out_port     <= w_out_port_d;
            r_write_strobe <= w_write_strobe_d;
            r_read_strobe  <= w_read_strobe_d;
            r_rsp_valid    <= w_rsp_valid_d;
            r_rsp_data     <= w_rsp_data_d;
            r_rsp_addr     <= w_rsp_addr_d;
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.port_id      = r_port_id;
    assign bus.out_port     = r_out_port;
    assign bus.write_strobe = r_write_strobe;
    assign bus.read_strobe  = r_read_strobe;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_addr     = r_rsp_addr;
    assign busy             = r_busy;

`ifdef PB_PORT_MASTER_IRQ_EN
    logic r_irq_meta;
    logic r_irq_sync;
    logic r_irq_prev;
    logic r_irq_pending;
    logic w_irq_rise;

    assign w_irq_rise = r_irq_sync && !r_irq_prev;

    // A new edge wins over a coincident clear so no interrupt is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_meta    <= 1'b0;
            r_irq_sync    <= 1'b0;
            r_irq_prev    <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            r_irq_meta <= interrupt;
            r_irq_sync <= r_irq_meta;
            r_irq_prev <= r_irq_sync;
            if (w_irq_rise) begin
                r_irq_pending <= 1'b1;
            end else if (irq_clear) begin
                r_irq_pending <= 1'b0;
            end
        end
    end

    assign irq_pending = r_irq_pending;
`else
    logic w_unused_irq;
    assign w_unused_irq = interrupt | irq_clear;
    assign irq_pending  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pb_port_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_port_master
// Brief    : Randomised self-checking bench for pb_port_master with a memory
//            responder and an address-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_port_master;

`ifdef PB_PORT_MASTER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic interrupt;
    logic irq_clear;
    logic irq_pending;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] resp_mem [256];
    logic [7:0] exp_mem  [256];
    logic [7:0] exp_out;

    always #5 clk = ~clk;

    pb_port_master_if bus_if ();

    pb_port_master #(.IDLE_PORT_ID(8'hFF)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .interrupt   (interrupt),
        .irq_clear   (irq_clear),
        .irq_pending (irq_pending),
        .busy        (busy)
    );

    // Registered port responder: returns the byte stored at the previous cycle's port_id.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) resp_mem[i] <= 8'(i) ^ 8'h3C;
        end else if (bus_if.write_strobe) begin
            resp_mem[bus_if.port_id] <= bus_if.out_port;
        end
        bus_if.in_port <= resp_mem[bus_if.port_id];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h3C;
        exp_out = 8'h00;
    endtask

    // Called just after a negedge with the master idle; returns likewise.
    task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
        check("wr_ready", bus_if.cmd_ready, 1);
        bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = addr; bus_if.cmd_wdata = data;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = 8'($urandom); bus_if.cmd_wdata = 8'($urandom);
        check("wr_setup_pid", bus_if.port_id, addr);
        check("wr_setup_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b00);
        check("wr_setup_rdy", {bus_if.cmd_ready, busy}, 2'b01);
        check("wr_setup_out", bus_if.out_port, data);
        @(negedge clk);
        check("wr_stb_pid", bus_if.port_id, addr);
        check("wr_stb_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b10);
        check("wr_stb_out", bus_if.out_port, data);
        exp_mem[addr] = data;
        exp_out       = data;
        @(negedge clk);
        check("wr_done_rdy", {bus_if.cmd_ready, busy, bus_if.rsp_valid}, 3'b100);
        check("wr_done_pid", bus_if.port_id, 8'hFF);
        check("wr_done_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b00);
    endtask

    task automatic do_read(input logic [7:0] addr, input int hold);
        check("rd_ready", bus_if.cmd_ready, 1);
        bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = addr;
        bus_if.rsp_ready = 1'b0;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0; bus_if.cmd_addr = 8'($urandom);
        check("rd_setup_pid", bus_if.port_id, addr);
        check("rd_setup_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b00);
        check("rd_setup_out", bus_if.out_port, exp_out);
        @(negedge clk);
        check("rd_stb_pid", bus_if.port_id, addr);
        check("rd_stb_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b01);
        @(negedge clk);
        check("rd_rsp_valid", {bus_if.rsp_valid, bus_if.cmd_ready, busy}, 3'b101);
        check("rd_rsp_data", bus_if.rsp_data, exp_mem[addr]);
        check("rd_rsp_addr", bus_if.rsp_addr, addr);
        check("rd_rsp_pid", bus_if.port_id, 8'hFF);
        check("rd_rsp_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b00);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("rd_hold_valid", {bus_if.rsp_valid, bus_if.cmd_ready}, 2'b10);
            check("rd_hold_data", {bus_if.rsp_data, bus_if.rsp_addr}, {exp_mem[addr], addr});
            check("rd_hold_stb", {bus_if.write_strobe, bus_if.read_strobe, bus_if.port_id}, {2'b00, 8'hFF});
        end
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        check("rd_done", {bus_if.rsp_valid, bus_if.cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; interrupt = 1'b0; irq_clear = 1'b0;
        bus_if.cmd_valid = 1'b0; bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 8'h00; bus_if.cmd_wdata = 8'h00; bus_if.rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", {bus_if.cmd_ready, busy, bus_if.rsp_valid, irq_pending}, 4'b0000);
        check("rst_pid", bus_if.port_id, 8'hFF);
        check("rst_out", {bus_if.out_port, bus_if.rsp_data, bus_if.rsp_addr}, 24'h0);
        check("rst_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b00);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_ready", bus_if.cmd_ready, 1);

        do_write(8'h01, 8'h5A);
        do_read(8'h01, 0);
        do_read(8'h01, 5);
        do_read(8'hC3, 1);

        // Back-to-back writes with cmd_valid held: one accept every third cycle.
        bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 8'h10; bus_if.cmd_wdata = 8'hA0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("b2b_wstb", bus_if.write_strobe, (i % 3) == 2);
            check("b2b_rstb", bus_if.read_strobe, 0);
            if (i == 12) bus_if.cmd_valid = 1'b0;
        end
        exp_mem[8'h10] = 8'hA0; exp_out = 8'hA0;
        check("b2b_out", bus_if.out_port, 8'hA0);
        do_read(8'h10, 0);

        // Reset during SETUP of a write.
        bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b1;
        bus_if.cmd_addr  = 8'h03; bus_if.cmd_wdata = 8'h77;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        check("rsw_setup_pid", bus_if.port_id, 8'h03);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rsw_stb", {bus_if.write_strobe, bus_if.read_strobe}, 2'b00);
        check("rsw_pid", bus_if.port_id, 8'hFF);
        check("rsw_vals", {bus_if.out_port, bus_if.cmd_ready, busy, bus_if.rsp_valid}, {8'h00, 3'b000});
        @(negedge clk);
        check("rsw_stb2", {bus_if.write_strobe, bus_if.read_strobe}, 2'b00);
        @(negedge clk);
        check("rsw_ready", bus_if.cmd_ready, 1);

        // Reset while a read response is pending discards it.
        bus_if.cmd_valid = 1'b1; bus_if.cmd_write = 1'b0; bus_if.cmd_addr = 8'h05;
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rsr_valid", bus_if.rsp_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("rsr_dropped", {bus_if.rsp_valid, bus_if.rsp_data, bus_if.rsp_addr}, 17'h0);
        repeat (2) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1) do_write(8'($urandom_range(15, 0)), 8'($urandom));
            else do_read(8'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
        end

        // Interrupt capture.
        interrupt = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_set", irq_pending, IRQ_ON);
        interrupt = 1'b0;
        repeat (3) @(negedge clk);
        check("irq_held", irq_pending, IRQ_ON);
        interrupt = 1'b1;
        repeat (2) @(negedge clk);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("irq_set_and_clear", irq_pending, IRQ_ON);
        @(negedge clk);
        irq_clear = 1'b1;
        @(negedge clk);
        irq_clear = 1'b0;
        check("irq_clear", irq_pending, 0);
        repeat (3) @(negedge clk);
        check("irq_level_no_reset", irq_pending, 0);
        interrupt = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
